// File: rtl/msa_pkg.sv
// Shared MSA definitions: decoder format codes, issue FSM state encoding and
// small format-classification helpers used by both the decoder and issue control.
package msa_pkg;

    localparam int LAT_W = 4;

    localparam logic [3:0] FMT_I8     = 4'd0;
    localparam logic [3:0] FMT_I5     = 4'd1;
    localparam logic [3:0] FMT_I10    = 4'd2;
    localparam logic [3:0] FMT_BIT    = 4'd3;
    localparam logic [3:0] FMT_3R     = 4'd4;
    localparam logic [3:0] FMT_ELM    = 4'd5;
    localparam logic [3:0] FMT_3RF    = 4'd6;
    localparam logic [3:0] FMT_2R     = 4'd7;
    localparam logic [3:0] FMT_2RF    = 4'd8;
    localparam logic [3:0] FMT_VEC    = 4'd9;
    localparam logic [3:0] FMT_MI10   = 4'd10;
    localparam logic [3:0] FMT_BRANCH = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MEM  = 2'd2,
        ST_WB   = 2'd3
    } msa_state_t;

    // Floating-point formats take the long execute latency.
    function automatic logic fmt_is_fp(input logic [3:0] fmt);
        return (fmt == FMT_3RF) || (fmt == FMT_2RF);
    endfunction

    // Formats that run through the execute pipe and write a vector register.
    function automatic logic fmt_is_compute(input logic [3:0] fmt);
        return fmt <= FMT_VEC;
    endfunction

    function automatic logic fmt_is_illegal(input logic [3:0] fmt);
        return fmt > FMT_BRANCH;
    endfunction

endpackage

// File: rtl/msa_lat_cnt.sv
// Execute-latency down-counter: loaded on issue, decremented while executing,
// done when the final execute cycle is reached.
module msa_lat_cnt
    import msa_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [LAT_W-1:0] load_val,
    input  logic             dec,
    output logic [LAT_W-1:0] count,
    output logic             done
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    // A count of 1 marks the last execute cycle; writeback follows it.
    assign done = (count == LAT_W'(1));

endmodule

// File: rtl/msa_issue_ctrl.sv
// MSA issue controller: single instruction in flight through IDLE/EXEC/MEM/WB.
// Define MSA_ISSUE_PERF_EN to add the saturating stall_cnt performance counter.
module msa_issue_ctrl
    import msa_pkg::*;
#(
    parameter int LAT_FP  = 4,
    parameter int LAT_INT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  format,
    input  logic [4:0]  wd,
    output logic        ex_start,
    output logic [3:0]  ex_fmt,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic        wb_en,
    output logic [4:0]  wb_reg,
    output logic        illegal,
`ifdef MSA_ISSUE_PERF_EN
    output logic [31:0] stall_cnt,
`endif
    output logic [1:0]  state_dbg
);

    localparam logic [LAT_W-1:0] LAT_FP_V  = LAT_FP[LAT_W-1:0];
    localparam logic [LAT_W-1:0] LAT_INT_V = LAT_INT[LAT_W-1:0];

    // Handshake: an instruction transfers on a rising edge where in_valid and
    // in_ready are both 1; in_ready depends only on state, never on in_valid.
    msa_state_t       state;
    msa_state_t       state_nxt;
    logic             accept;
    logic             is_compute;
    logic             is_mem;
    logic             is_branch;
    logic             is_bad;
    logic             cnt_load;
    logic [LAT_W-1:0] cnt_val;
    logic [LAT_W-1:0] cnt;
    logic             cnt_done;
    logic [4:0]       wd_q;

    assign accept     = in_valid && in_ready;
    assign is_compute = fmt_is_compute(format);
    assign is_mem     = (format == FMT_MI10);
    assign is_branch  = (format == FMT_BRANCH);
    assign is_bad     = fmt_is_illegal(format);
    assign cnt_load   = accept && is_compute;
    assign cnt_val    = fmt_is_fp(format) ? LAT_FP_V : LAT_INT_V;

    msa_lat_cnt u_lat_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (state == ST_EXEC),
        .count    (cnt),
        .done     (cnt_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (accept && is_compute) begin
                    state_nxt = ST_EXEC;
                end else if (accept && is_mem) begin
                    state_nxt = ST_MEM;
                end
            end
            ST_EXEC: begin
                if (cnt_done) begin
                    state_nxt = ST_WB;
                end
            end
            ST_MEM: begin
                if (mem_ack) begin
                    state_nxt = ST_WB;
                end
            end
            ST_WB: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        in_ready  = (state == ST_IDLE);
        mem_req   = (state == ST_MEM);
        wb_en     = (state == ST_WB);
        wb_reg    = wd_q;
        state_dbg = state;
    end

    // Illegal formats must leave the latched instruction fields untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_start <= 1'b0;
            illegal  <= 1'b0;
            ex_fmt   <= '0;
            wd_q     <= '0;
        end else begin
            ex_start <= accept && (is_compute || is_branch);
            illegal  <= accept && is_bad;
            if (accept && !is_bad) begin
                ex_fmt <= format;
                wd_q   <= wd;
            end
        end
    end

`ifdef MSA_ISSUE_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (in_valid && !in_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_msa_issue_ctrl.sv
// Directed self-checking bench for msa_issue_ctrl with default latencies
// (LAT_INT=1, LAT_FP=4); expected values are hand-derived cycle by cycle.
module tb_msa_issue_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  format;
    logic [4:0]  wd;
    logic        ex_start;
    logic [3:0]  ex_fmt;
    logic        mem_req;
    logic        mem_ack;
    logic        wb_en;
    logic [4:0]  wb_reg;
    logic        illegal;
    logic [1:0]  state_dbg;
`ifdef MSA_ISSUE_PERF_EN
    logic [31:0] stall_cnt;
`endif

    int checks;
    int errors;
    int wb_seen;
    int ill_seen;
    int wb_before;
    logic [4:0] exp_q[$];

    msa_issue_ctrl #(
        .LAT_FP  (4),
        .LAT_INT (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .format    (format),
        .wd        (wd),
        .ex_start  (ex_start),
        .ex_fmt    (ex_fmt),
        .mem_req   (mem_req),
        .mem_ack   (mem_ack),
        .wb_en     (wb_en),
        .wb_reg    (wb_reg),
        .illegal   (illegal),
`ifdef MSA_ISSUE_PERF_EN
        .stall_cnt (stall_cnt),
`endif
        .state_dbg (state_dbg)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Pulse monitor sampled away from the active edge
    always @(negedge clk) begin
        if (!rst && wb_en) wb_seen++;
        if (!rst && illegal) ill_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present an instruction for the current cycle; it is accepted at the next edge.
    task automatic drive(input logic [3:0] f, input logic [4:0] d);
        in_valid = 1'b1;
        format   = f;
        wd       = d;
        if (f <= 4'd10) exp_q.push_back(d);
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        format   = 4'd0;
        wd       = 5'd0;
    endtask

    task automatic check_wb(input string tag);
        logic [4:0] exp_reg;
        check({tag, "_wb_en"}, 32'(wb_en), 32'd1);
        exp_reg = (exp_q.size() != 0) ? exp_q.pop_front() : 5'd0;
        check({tag, "_wb_reg"}, 32'(wb_reg), 32'(exp_reg));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_ex_start"}, 32'(ex_start), 32'd0);
        check({tag, "_mem_req"},  32'(mem_req),  32'd0);
        check({tag, "_wb_en"},    32'(wb_en),    32'd0);
        check({tag, "_illegal"},  32'(illegal),  32'd0);
        check({tag, "_ex_fmt"},   32'(ex_fmt),   32'd0);
        check({tag, "_wb_reg"},   32'(wb_reg),   32'd0);
        check({tag, "_state"},    32'(state_dbg), 32'd0);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        wb_seen  = 0;
        ill_seen = 0;
        rst      = 1'b1;
        mem_ack  = 1'b0;
        idle_in();
        tick();
        tick();
        check_reset_outputs("reset");
`ifdef MSA_ISSUE_PERF_EN
        check("reset_stall_cnt", stall_cnt, 32'd0);
`endif
        rst = 1'b0;
        tick();

        // Compute format 3R, LAT_INT=1: ex_start T+1, wb T+2, ready T+3
        drive(4'd4, 5'd7);
        check("s1_ready_T", 32'(in_ready), 32'd1);
        tick();
        idle_in();
        check("s1_ex_start", 32'(ex_start), 32'd1);
        check("s1_ex_fmt", 32'(ex_fmt), 32'd4);
        check("s1_ready_T1", 32'(in_ready), 32'd0);
        check("s1_wb_T1", 32'(wb_en), 32'd0);
        check("s1_state_T1", 32'(state_dbg), 32'd1);
        tick();
        check_wb("s1");
        check("s1_ex_start_T2", 32'(ex_start), 32'd0);
        tick();
        check("s1_ready_T3", 32'(in_ready), 32'd1);
        check("s1_wb_T3", 32'(wb_en), 32'd0);

        // FP format 3RF, LAT_FP=4: busy T+1..T+5, wb T+5; stray mem_ack ignored
        drive(4'd6, 5'd3);
        for (int i = 1; i <= 5; i++) begin
            tick();
            idle_in();
            mem_ack = (i == 2);
            check($sformatf("s2_ready_T%0d", i), 32'(in_ready), 32'd0);
            check($sformatf("s2_ex_start_T%0d", i), 32'(ex_start), (i == 1) ? 32'd1 : 32'd0);
            if (i == 5) check_wb("s2");
            else check($sformatf("s2_wb_T%0d", i), 32'(wb_en), 32'd0);
        end
        mem_ack = 1'b0;
        tick();
        check("s2_ready_T6", 32'(in_ready), 32'd1);

        // Back-to-back: accept in the cycle right after WB
        drive(4'd0, 5'd31);
        tick();
        idle_in();
        check("b2b_ex_start", 32'(ex_start), 32'd1);
        tick();
        check_wb("b2b");

        // mem_ack while idle must not move the FSM
        tick();
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("idle_ack_state", 32'(state_dbg), 32'd0);
        check("idle_ack_wb", 32'(wb_en), 32'd0);

        // MI10: mem_req T+1..T+6, mem_ack in T+6, wb T+7
        drive(4'd10, 5'd12);
        for (int i = 1; i <= 6; i++) begin
            tick();
            idle_in();
            check($sformatf("s3_mem_req_T%0d", i), 32'(mem_req), 32'd1);
            check($sformatf("s3_wb_T%0d", i), 32'(wb_en), 32'd0);
            mem_ack = (i == 6);
        end
        tick();
        mem_ack = 1'b0;
        check("s3_mem_req_T7", 32'(mem_req), 32'd0);
        check_wb("s3");
        tick();
        check("s3_ready_T8", 32'(in_ready), 32'd1);

        // Branch then illegal 14: no writeback, one illegal pulse
        wb_before = wb_seen;
        drive(4'd11, 5'd9);
        tick();
        drive(4'd14, 5'd20);
        check("s4_br_ex_start", 32'(ex_start), 32'd1);
        check("s4_br_ex_fmt", 32'(ex_fmt), 32'd11);
        check("s4_br_ready", 32'(in_ready), 32'd1);
        check("s4_br_illegal", 32'(illegal), 32'd0);
        tick();
        idle_in();
        check("s4_ill_pulse", 32'(illegal), 32'd1);
        check("s4_ill_ex_start", 32'(ex_start), 32'd0);
        check("s4_ill_ex_fmt", 32'(ex_fmt), 32'd11);
        check("s4_ill_ready", 32'(in_ready), 32'd1);
        tick();
        check("s4_ill_drop", 32'(illegal), 32'd0);
        for (int i = 0; i < 4; i++) tick();
        check("s4_no_wb", 32'(wb_seen), 32'(wb_before));
        check("s4_ill_count", 32'(ill_seen), 32'd1);

        // Reset in EXEC at count 2 of a 3RF op: immediate clear, no later wb
        drive(4'd6, 5'd5);
        tick();
        idle_in();
        tick();
        tick();
        check("s5_in_exec", 32'(state_dbg), 32'd1);
        rst = 1'b1;
        #1;
        check_reset_outputs("s5_async");
        void'(exp_q.pop_back());
        wb_before = wb_seen;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("s5_no_wb", 32'(wb_seen), 32'(wb_before));
        check("s5_ready", 32'(in_ready), 32'd1);

`ifdef MSA_ISSUE_PERF_EN
        // in_valid held through one 3RF op: five stalled cycles
        drive(4'd6, 5'd1);
        for (int i = 0; i < 6; i++) tick();
        idle_in();
        check("perf_stall_cnt", stall_cnt, 32'd5);
        for (int i = 0; i < 3; i++) tick();
        void'(exp_q.pop_front());
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/msa_issue_ctrl.md
MSA_ISSUE_CTRL -- requirements
Module: msa_issue_ctrl

Interface
REQ-001 SHALL have parameter LAT_FP, default 4, meaning execute cycles for 3RF/2RF formats (legal range 1..15).
REQ-002 SHALL have parameter LAT_INT, default 1, meaning execute cycles for I8/I5/I10/BIT/3R/ELM/2R/VEC (legal range 1..15).
REQ-003 SHALL have port clk, input, 1, the single clock; all state on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, decoded instruction present.
REQ-006 SHALL have port in_ready, output, 1, controller accepts the instruction.
REQ-007 SHALL have port format, input, 4, decoder format code: 0 I8, 1 I5, 2 I10, 3 BIT, 4 3R, 5 ELM, 6 3RF, 7 2R, 8 2RF, 9 VEC, 10 MI10, 11 branch, 12-15 illegal.
REQ-008 SHALL have port wd, input, 5, destination vector register.
REQ-009 SHALL have port ex_start, output, 1, one-cycle datapath start pulse.
REQ-010 SHALL have port ex_fmt, output, 4, registered format of the in-flight instruction.
REQ-011 SHALL have port mem_req, output, 1, load/store request, held until mem_ack.
REQ-012 SHALL have port mem_ack, input, 1, memory completion.
REQ-013 SHALL have port wb_en, output, 1, one-cycle register-file write pulse.
REQ-014 SHALL have port wb_reg, output, 5, write address, valid with wb_en.
REQ-015 SHALL have port illegal, output, 1, one-cycle pulse on an accepted illegal format.

Function
REQ-016 SHALL implement FSM states IDLE, EXEC, MEM, WB; one instruction in flight.
REQ-017 in_ready SHALL be 1 only in IDLE; accept = in_valid & in_ready.
REQ-018 On accept with format 0-9, SHALL latch format and wd, pulse ex_start in the next cycle, load the counter with LAT_INT or LAT_FP, and go to EXEC.
REQ-019 EXEC SHALL decrement the counter each cycle and go to WB when the counter reaches 1.
REQ-020 On accept with format 10 (MI10), SHALL go to MEM with mem_req=1 from the next cycle and stay until mem_ack=1, then go to WB.
REQ-021 mem_ack outside MEM SHALL be ignored.
REQ-022 On accept with format 11 (branch), SHALL pulse ex_start and return to IDLE with no wb_en.
REQ-023 On accept with format 12-15, SHALL pulse illegal next cycle, stay in IDLE, and issue nothing.
REQ-024 WB SHALL assert wb_en=1 with wb_reg=latched wd for exactly one cycle, then go to IDLE.
REQ-025 Total latency accept->wb_en SHALL be LAT+1 cycles for compute formats and (mem_ack cycle)+1 for MI10.
REQ-026 Back-to-back SHALL be supported: a new accept is possible in the cycle after WB.

Reset
REQ-027 rst=1 SHALL immediately force IDLE, counter=0, and in_ready=1, with ex_start, mem_req, wb_en, and illegal at 0 and ex_fmt and wb_reg at 0.
REQ-028 Reset mid-EXEC or mid-MEM SHALL abandon the instruction with no wb_en after reset release.

Configuration
REQ-029 With MSA_ISSUE_PERF_EN defined, SHALL add output stall_cnt (32-bit), counting cycles with in_valid=1 and in_ready=0, saturating at 0xFFFFFFFF, and cleared by rst.
REQ-030 Without MSA_ISSUE_PERF_EN, port stall_cnt and its counter SHALL be absent.

Structure
REQ-031 Format code constants (the 12 codes) and FSM state encodings SHALL live in shared package msa_pkg, also used by the decoder.
REQ-032 The latency counter SHALL be sub-module msa_lat_cnt (load, decrement, done flag).

Verification
REQ-033 Scenario: accept format=4, wd=7, LAT_INT=1 -> ex_start at T+1, wb_en with wb_reg=7 at T+2, in_ready=1 at T+3.
REQ-034 Scenario: accept format=6, wd=3, LAT_FP=4 -> wb_en at T+5, in_ready=0 during T+1..T+5.
REQ-035 Scenario: accept format=10, wd=12, mem_ack at T+6 -> mem_req=1 during T+1..T+6, wb_en with wb_reg=12 at T+7.
REQ-036 Scenario: format=11, then format=14 -> no wb_en for either; illegal pulses once for format=14.
REQ-037 Scenario: rst at EXEC count 2 of format=6 -> all outputs 0 and in_ready=1 immediately, no later wb_en.
REQ-038 Scenario (MSA_ISSUE_PERF_EN): in_valid held through one format=6 (LAT_FP=4) op -> stall_cnt=5.
